exibe_sequencia: RTL and testbench
==================================

# exibe_sequencia

Sequence presenter for the memory game: on request, reads the stored sequence from the 16x4 synchronous ROM/RAM, positions 0 through the current round, and shows each value on the LEDs for a fixed on-time followed by a blank gap. It is the output-side counterpart of the player-input datapath, which reads the same memory and compares it against the switches. It sits between the game controller and the memory, sharing the memory address bus when the controller grants it.

## Interface

Parameters:
- `ON_CYCLES`, default 1000: clock cycles each value stays lit. Must be ≥1.
- `OFF_CYCLES`, default 500: clock cycles of blank LEDs after each value. Must be ≥1.

Ports:
- `clock`: input, 1 bit. System clock; all state changes on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high reset.
- `iniciar`: input, 1 bit. Start request; sampled only in INICIAL.
- `rodada`: input, 4 bits. Last index to display, inclusive; latched at start.
- `mem_dado`: input, 4 bits. Memory read data; valid one cycle after `mem_addr` is presented.
- `mem_addr`: output, 4 bits. Memory read address.
- `leds`: output, 4 bits. Displayed value; 0 when blank.
- `ocupado`: output, 1 bit. High while a presentation is in progress.
- `pronto`: output, 1 bit. One-cycle pulse when the presentation completes.
- `db_estado`: output, 4 bits. State encoding, for debug.

## Operation

- States and `db_estado` encodings: INICIAL=0, BUSCA=1, CARREGA=2, ACESO=3, APAGADO=4, FIM=5. All other encodings go to INICIAL on the next edge.
- INICIAL:
  - `ocupado`=0, `leds`=0, address counter held at 0.
  - `iniciar`=1 → BUSCA, with `rodada` captured into `rodada_reg`.
- BUSCA: `mem_addr`=address counter. Always → CARREGA (the memory registers the address at this edge).
- CARREGA: `mem_dado` is valid. The `leds` register loads `mem_dado`, the timer clears, → ACESO.
- ACESO:
  - `leds` holds the loaded value; the timer counts.
  - After `ON_CYCLES` cycles in ACESO: `leds` clears, the timer clears, → APAGADO.
- APAGADO:
  - `leds`=0; the timer counts.
  - After `OFF_CYCLES` cycles: if address == `rodada_reg` → FIM; else address+1 → BUSCA.
- FIM: `pronto`=1 and `ocupado`=0 for one cycle, address cleared, → INICIAL.
- `ocupado`=1 in BUSCA, CARREGA, ACESO and APAGADO.
- `iniciar` is ignored in every state except INICIAL. Changes on `rodada` after start are ignored.
- A memory value of 0 displays as blank; no special handling.
- `rodada`=15 shows 16 values and ends at address 15. The address never wraps.
- Timer width is large enough to hold max(`ON_CYCLES`, `OFF_CYCLES`). It clears on every state entry.

## Timing

- Reset values: state INICIAL, address 0, `mem_addr`=0, `leds`=0, `ocupado`=0, `pronto`=0, `db_estado`=0, timer 0, `rodada_reg`=0.
- Asserting `reset` in any state forces these values immediately, independent of `clock`. No `pronto` pulse is generated.
- With `iniciar` sampled high at edge 0:
  - BUSCA at edge 1; `ocupado` rises at edge 1.
  - CARREGA at edge 2.
  - `leds` shows element 0 from edge 3 to edge 3+`ON_CYCLES`.
  - Blank until edge 3+`ON_CYCLES`+`OFF_CYCLES`.
- Period per element: 2+`ON_CYCLES`+`OFF_CYCLES` cycles.
- Cycle counts for `rodada`=r:
  - `pronto` is high during the cycle after edge 1+(r+1)(2+`ON_CYCLES`+`OFF_CYCLES`).
  - `iniciar` can be accepted again one cycle after that.
- `iniciar` held high continuously restarts the presentation immediately after each FIM.

## Configuration

- Macro: `EXIBE_SEQUENCIA_ABORTA_EN`.
- When defined:
  - Adds input port `abortar` (1 bit).
  - `abortar`=1 in BUSCA, CARREGA, ACESO or APAGADO → INICIAL at the next edge, with `leds`=0, address 0 and `ocupado`=0.
  - No `pronto` pulse is generated.
  - In INICIAL, `abortar` has priority over `iniciar`.
- When undefined: the port does not exist, and a presentation always runs to FIM unless `reset` is asserted.

## Test plan

Test parameters are `ON_CYCLES`=3, `OFF_CYCLES`=2; memory contents are 0x1,0x2,0x4,0x8,…

- Reset: assert `reset` mid-ACESO → `leds`=0, `ocupado`=0, `db_estado`=0 with no clock edge. Release, hold `iniciar`=0 for 20 cycles → no activity.
- Single element, `rodada`=0:
  - `iniciar` pulse → `leds`=0x1 for exactly 3 cycles starting 3 edges after start, then 0 for 2 cycles.
  - `pronto` high for 1 cycle at 1+7 edges after start; `ocupado` high for exactly 7 cycles.
- Round 3:
  - `rodada`=3 → `leds` sequence 0x1,0x2,0x4,0x8, each 3 cycles lit with gaps ≥2.
  - `mem_addr` steps 0..3.
  - `pronto` at edge 29.
- Ignore inputs while busy: pulse `iniciar` and change `rodada` to 9 during ACESO → no effect; run still ends after 4 elements.
- Full length: `rodada`=15 → 16 elements shown; `mem_addr` reaches 15 and does not wrap to 0 before FIM; `pronto` at edge 113.
- Abort, with `EXIBE_SEQUENCIA_ABORTA_EN` defined: `abortar` pulse during the second APAGADO → INICIAL next edge, `leds`=0, `ocupado`=0, no `pronto`. A following `iniciar` restarts from address 0.

Source files
------------

// File: rtl/exibe_sequencia.sv
// Sequence presenter: reads positions 0..rodada from the game memory and shows each on the LEDs
// for ON_CYCLES, then blanks them for OFF_CYCLES. Optional abort input: EXIBE_SEQUENCIA_ABORTA_EN.
module exibe_sequencia #(
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
`ifdef EXIBE_SEQUENCIA_ABORTA_EN
  input  logic       abortar,
`endif
  input  logic [3:0] rodada,
  input  logic [3:0] mem_dado,
  output logic [3:0] mem_addr,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam logic [2:0] INICIAL = 3'd0;
  localparam logic [2:0] BUSCA   = 3'd1;
  localparam logic [2:0] CARREGA = 3'd2;
  localparam logic [2:0] ACESO   = 3'd3;
  localparam logic [2:0] APAGADO = 3'd4;
  localparam logic [2:0] FIM     = 3'd5;

  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW         = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

  logic [2:0]    state;
  logic [2:0]    next;
  logic [3:0]    addr;
  logic [3:0]    rodada_reg;
  logic [TW-1:0] timer;
  logic          timer_fim;
  logic          busy;
  logic          abort_req;

`ifdef EXIBE_SEQUENCIA_ABORTA_EN
  assign abort_req = abortar;
`else
  assign abort_req = 1'b0;
`endif

  assign busy      = (state == BUSCA) || (state == CARREGA) || (state == ACESO) || (state == APAGADO);
  assign timer_fim = ((state == ACESO)   && (timer == TW'(ON_CYCLES - 1))) ||
                     ((state == APAGADO) && (timer == TW'(OFF_CYCLES - 1)));

  assign mem_addr  = addr;
  assign ocupado   = busy;
  assign pronto    = (state == FIM);
  assign db_estado = {1'b0, state};

  // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    next = state;
    case (state)
      INICIAL: if (iniciar && !abort_req) next = BUSCA;
      BUSCA:   next = CARREGA;
      CARREGA: next = ACESO;
      ACESO:   if (timer_fim) next = APAGADO;
      APAGADO: if (timer_fim) next = (addr == rodada_reg) ? FIM : BUSCA;
      FIM:     next = INICIAL;
      default: next = INICIAL;
    endcase
    if (abort_req && busy) next = INICIAL;
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= INICIAL;
      addr       <= '0;
      rodada_reg <= '0;
      timer      <= '0;
      leds       <= '0;
    end else begin
      state <= next;

      // The timer restarts on every state entry, so each phase counts from zero.
      if (next != state)
        timer <= '0;
      else if ((state == ACESO) || (state == APAGADO))
        timer <= timer + 1'b1;
      else
        timer <= '0;

      case (state)
        CARREGA: leds <= mem_dado;
        ACESO:   if (timer_fim) leds <= '0;
        default: leds <= '0;
      endcase

      case (state)
        INICIAL: begin
          addr <= '0;
          if (iniciar && !abort_req) rodada_reg <= rodada;
        end
        APAGADO: if (timer_fim && (addr != rodada_reg)) addr <= addr + 1'b1;
        FIM:     addr <= '0;
        default: ;
      endcase

      if (abort_req && busy) begin
        leds <= '0;
        addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Scoreboard bench for exibe_sequencia with ON_CYCLES=3, OFF_CYCLES=2 and memory word i = 1<<(i%4).
module tb_exibe_sequencia;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int PER = 2 + ON + OFF;

  logic       clk = 1'b0;
  logic       reset;
  logic       iniciar = 1'b0;
  logic       abortar = 1'b0;
  logic [3:0] rodada = '0;
  logic [3:0] mem_dado = '0;
  logic [3:0] mem_addr;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  always #5 clk = ~clk;

  exibe_sequencia #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clock    (clk),
    .reset    (reset),
    .iniciar  (iniciar),
`ifdef EXIBE_SEQUENCIA_ABORTA_EN
    .abortar  (abortar),
`endif
    .rodada   (rodada),
    .mem_dado (mem_dado),
    .mem_addr (mem_addr),
    .leds     (leds),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .db_estado(db_estado)
  );

  logic [3:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 4'b0001 << (i % 4);
  always @(posedge clk) mem_dado <= mem[mem_addr];

  typedef struct {
    bit         is_pronto;
    logic [3:0] val;
    logic [3:0] addr;
    int         at_edge;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  int   start_edge = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: turns DUT activity into lit/pronto events and compares them with the queue head.
  logic [3:0] prev_leds = '0;
  logic [3:0] busca_addr = '0;
  logic [3:0] lit_val = '0;
  logic [3:0] lit_addr = '0;
  int         lit_start = 0;
  int         lit_len = 0;
  int         occ_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (db_estado == 4'd1) busca_addr = mem_addr;
      if (leds != 0) begin
        if (prev_leds == 0) begin
          lit_start = edge_cnt - start_edge;
          lit_len   = 0;
          lit_val   = leds;
          lit_addr  = busca_addr;
        end
        lit_len++;
      end else if (prev_leds != 0) begin
        if (exp_q.size() == 0) check("unexpected_lit", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("event_kind_lit", 0, int'(e.is_pronto));
          check("lit_value", int'(lit_val), int'(e.val));
          check("lit_addr", int'(lit_addr), int'(e.addr));
          check("lit_start_edge", lit_start, e.at_edge);
          check("lit_length", lit_len, e.len);
        end
      end
      if (pronto) begin
        if (exp_q.size() == 0) check("unexpected_pronto", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("event_kind_pronto", 1, int'(e.is_pronto));
          check("pronto_edge", edge_cnt - start_edge, e.at_edge);
          check("ocupado_cycles", occ_cnt, e.len);
        end
      end
      if (ocupado) occ_cnt++;
      else occ_cnt = 0;
    end
    prev_leds = leds;
  end

  task automatic push_lits(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.is_pronto = 1'b0;
      e.val       = 4'b0001 << (i % 4);
      e.addr      = 4'(i);
      e.at_edge   = 3 + i * PER;
      e.len       = ON;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_run(input int r);
    exp_t e;
    push_lits(r + 1);
    e.is_pronto = 1'b1;
    e.val       = '0;
    e.addr      = '0;
    e.at_edge   = 1 + (r + 1) * PER;
    e.len       = (r + 1) * PER;
    exp_q.push_back(e);
  endtask

  task automatic launch(input int r);
    @(negedge clk);
    start_edge = edge_cnt;
    rodada     = 4'(r);
    iniciar    = 1'b1;
    @(negedge clk);
    iniciar    = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, input string name);
    int n = 0;
    while (db_estado != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (db_estado != st) check(name, int'(db_estado), int'(st));
  endtask

  task automatic wait_pronto(input int budget, input string name);
    int n = 0;
    while (!pronto && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!pronto) check(name, 0, 1);
  endtask

  initial begin
    int act;
    reset = 1'b1;
    #1;
    check("rst_leds", int'(leds), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_pronto", int'(pronto), 0);
    check("rst_db_estado", int'(db_estado), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset in the middle of a lit phase.
    launch(3);
    wait_state(4'd3, 20, "reach_aceso");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_leds", int'(leds), 0);
    check("async_rst_ocupado", int'(ocupado), 0);
    check("async_rst_db_estado", int'(db_estado), 0);
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (ocupado || leds != 0 || db_estado != 0 || pronto) act++;
    end
    check("idle_activity", act, 0);

    mon_en = 1'b1;

    // Single element.
    push_run(0);
    launch(0);
    wait_pronto(50, "pronto_timeout_r0");

    // Round 3, with start and round changes while busy.
    push_run(3);
    launch(3);
    wait_state(4'd3, 20, "reach_aceso_r3");
    iniciar = 1'b1;
    rodada  = 4'd9;
    @(negedge clk);
    iniciar = 1'b0;
    wait_pronto(100, "pronto_timeout_r3");

    // Full length: 16 elements, address stops at 15.
    push_run(15);
    launch(15);
    wait_pronto(300, "pronto_timeout_r15");
    repeat (5) @(negedge clk);
    check("idle_after_full", int'(ocupado), 0);

`ifdef EXIBE_SEQUENCIA_ABORTA_EN
    begin
      int entries = 0;
      int n = 0;
      logic [3:0] prev_st = '0;
      push_lits(2);
      launch(3);
      while (entries < 2 && n < 100) begin
        @(negedge clk);
        n++;
        if (db_estado == 4'd4 && prev_st != 4'd4) entries++;
        prev_st = db_estado;
      end
      check("reach_second_apagado", entries, 2);
      abortar = 1'b1;
      @(negedge clk);
      abortar = 1'b0;
      check("abort_db_estado", int'(db_estado), 0);
      check("abort_leds", int'(leds), 0);
      check("abort_ocupado", int'(ocupado), 0);
      repeat (10) @(negedge clk);
      push_run(0);
      launch(0);
      wait_pronto(50, "pronto_timeout_after_abort");
    end
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
